// File: rtl/m68k_bus_decoder.sv
// m68k_bus_decoder: runtime-loadable region table decoding a 68000 bus cycle
// into a registered one-hot chip select, wait-state count and DTACK handshake.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   cfg_we/cfg_idx/...   table write port (one entry per cycle, idx >= NREG ignored)
//   cpu_a/cpu_as_n/cpu_rw  CPU address, address strobe (active low), read/write
//   ext_ready            external data ready for entries flagged ext
//   cs, hit_idx          registered one-hot select and its index
//   dtack_n              data acknowledge (active low)
//   unmapped             one-cycle pulse when an access matches no region
//   busy                 bus cycle in progress
module m68k_bus_decoder #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 24,
  parameter int unsigned DB       = 20,
  parameter int unsigned WSW      = 4,
  parameter int unsigned UNMAP_WS = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [5:0]      cfg_idx,
  input  logic            cfg_en,
  input  logic [DB-1:0]   cfg_start,
  input  logic [DB-1:0]   cfg_end,
  input  logic [WSW-1:0]  cfg_ws,
  input  logic [1:0]      cfg_rwm,
  input  logic            cfg_ext,
  input  logic [AW-1:0]   cpu_a,
  input  logic            cpu_as_n,
  input  logic            cpu_rw,
  input  logic            ext_ready,
  output logic [NREG-1:0] cs,
  output logic [5:0]      hit_idx,
  output logic            dtack_n,
  output logic            unmapped,
  output logic            busy
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [1:0] RWM_ANY = 2'd0;
  localparam logic [1:0] RWM_RO  = 2'd1;
  localparam logic [1:0] RWM_WO  = 2'd2;

  typedef struct packed {
    logic           en;
    logic [DB-1:0]  start_a;
    logic [DB-1:0]  end_a;
    logic [WSW-1:0] ws;
    logic [1:0]     rwm;
    logic           ext;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_DONE
  } state_t;

  state_t         state;
  entry_t         tbl [NREG];
  logic [DB-1:0]  addr_q;
  logic           rw_q;
  logic [WSW-1:0] cnt;
  logic           ext_q;
  logic           match_hit;
  logic [IW-1:0]  match_sel;

  // Upper address bits are deliberately ignored (mirroring).
  logic unused_upper;
  assign unused_upper = ^cpu_a[AW-1:DB];

  function automatic logic entry_match(input entry_t e, input logic [DB-1:0] a,
                                       input logic rd);
    logic rw_ok;
    case (e.rwm)
      RWM_ANY: rw_ok = 1'b1;
      RWM_RO:  rw_ok = rd;
      RWM_WO:  rw_ok = ~rd;
      default: rw_ok = 1'b0;
    endcase
    return e.en && (a >= e.start_a) && (a <= e.end_a) && rw_ok;
  endfunction

  // Priority encoder: scanning downward lets the lowest matching index win.
  always_comb begin
    match_hit = 1'b0;
    match_sel = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (entry_match(tbl[i], addr_q, rw_q)) begin
        match_hit = 1'b1;
        match_sel = IW'(i);
      end
    end
  end

  // Table write port and bus-cycle FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cs       <= '0;
      hit_idx  <= '0;
      dtack_n  <= 1'b1;
      unmapped <= 1'b0;
      busy     <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      cnt      <= '0;
      ext_q    <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        tbl[i] <= '0;
      end
    end else begin
      unmapped <= 1'b0;

      if (cfg_we && (32'(cfg_idx) < NREG)) begin
        tbl[cfg_idx[IW-1:0]] <= '{en: cfg_en, start_a: cfg_start, end_a: cfg_end,
                                  ws: cfg_ws, rwm: cfg_rwm, ext: cfg_ext};
      end

      case (state)
        S_IDLE: begin
          if (!cpu_as_n) begin
            addr_q <= cpu_a[DB-1:0];
            rw_q   <= cpu_rw;
            busy   <= 1'b1;
            state  <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (cpu_as_n) begin
            cs      <= '0;
            dtack_n <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else if (match_hit) begin
            cs      <= NREG'(1) << match_sel;
            hit_idx <= 6'(match_sel);
            cnt     <= tbl[match_sel].ws;
            ext_q   <= tbl[match_sel].ext;
            state   <= S_WAIT;
          end else begin
            cs       <= '0;
            hit_idx  <= '0;
            unmapped <= 1'b1;
            cnt      <= WSW'(UNMAP_WS);
            ext_q    <= 1'b0;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cpu_as_n) begin
            cs      <= '0;
            dtack_n <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else if (cnt == '0) begin
            // An ext entry stalls here until the external device is ready.
            if (!ext_q || ext_ready) begin
              state <= S_ACK;
            end
          end else begin
            cnt <= cnt - WSW'(1);
          end
        end

        S_ACK: begin
          if (cpu_as_n) begin
            cs      <= '0;
            dtack_n <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else begin
            dtack_n <= 1'b0;
          end
        end

        S_DONE: begin
          // One dead cycle so a still-low strobe cannot start a spurious decode.
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// tb_m68k_bus_decoder: directed vector table, multi-cycle corner sequences and
// randomized accesses against a region-table reference model.
module tb_m68k_bus_decoder;

  localparam int unsigned NREG     = 32;
  localparam int unsigned AW       = 24;
  localparam int unsigned DB       = 20;
  localparam int unsigned WSW      = 4;
  localparam int unsigned UNMAP_WS = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [5:0]      cfg_idx;
  logic            cfg_en;
  logic [DB-1:0]   cfg_start;
  logic [DB-1:0]   cfg_end;
  logic [WSW-1:0]  cfg_ws;
  logic [1:0]      cfg_rwm;
  logic            cfg_ext;
  logic [AW-1:0]   cpu_a;
  logic            cpu_as_n;
  logic            cpu_rw;
  logic            ext_ready;
  logic [NREG-1:0] cs;
  logic [5:0]      hit_idx;
  logic            dtack_n;
  logic            unmapped;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference model of the region table.
  bit             m_en   [NREG];
  int             m_start[NREG];
  int             m_end  [NREG];
  int             m_ws   [NREG];
  int             m_rwm  [NREG];
  bit             m_ext  [NREG];

  typedef struct {
    logic [AW-1:0] a;
    logic          rw;
    int            idx;
    int            lat;
  } vec_t;

  vec_t vecs[15];

  m68k_bus_decoder #(
    .NREG(NREG), .AW(AW), .DB(DB), .WSW(WSW), .UNMAP_WS(UNMAP_WS)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_start(cfg_start),
    .cfg_end(cfg_end), .cfg_ws(cfg_ws), .cfg_rwm(cfg_rwm), .cfg_ext(cfg_ext),
    .cpu_a(cpu_a), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw), .ext_ready(ext_ready),
    .cs(cs), .hit_idx(hit_idx), .dtack_n(dtack_n), .unmapped(unmapped), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NREG); i++) begin
      m_en[i] = 0; m_start[i] = 0; m_end[i] = 0; m_ws[i] = 0; m_rwm[i] = 0; m_ext[i] = 0;
    end
  endtask

  task automatic cfg_write(input int idx, input bit en, input int s, input int e,
                           input int ws, input int rwm, input bit ext);
    cfg_idx   = 6'(idx);
    cfg_en    = en;
    cfg_start = DB'(s);
    cfg_end   = DB'(e);
    cfg_ws    = WSW'(ws);
    cfg_rwm   = 2'(rwm);
    cfg_ext   = ext;
    cfg_we    = 1'b1;
    step();
    cfg_we    = 1'b0;
    if (idx < int'(NREG)) begin
      m_en[idx] = en; m_start[idx] = s; m_end[idx] = e;
      m_ws[idx] = ws; m_rwm[idx] = rwm; m_ext[idx] = ext;
    end
  endtask

  // First region whose inclusive range holds the folded address and whose
  // direction rule allows the access; -1 when none does.
  function automatic int model_hit(input logic [AW-1:0] a, input logic rw);
    int off;
    bit dir_ok;
    off = int'(a) % (1 << DB);
    for (int i = 0; i < int'(NREG); i++) begin
      dir_ok = (m_rwm[i] == 0) || (m_rwm[i] == 1 && rw) || (m_rwm[i] == 2 && !rw);
      if (m_en[i] && off >= m_start[i] && off <= m_end[i] && dir_ok) return i;
    end
    return -1;
  endfunction

  // Full bus cycle; lat = edges from the strobe-sampling edge to dtack_n low.
  task automatic do_access(input logic [AW-1:0] a, input logic rw, input int exp_idx,
                           input int exp_lat, input string tag);
    logic [NREG-1:0] exp_cs;
    int  k;
    bit  cs_bad;
    exp_cs = (exp_idx >= 0) ? (NREG'(1) << exp_idx) : '0;
    cpu_a = a; cpu_rw = rw; cpu_as_n = 1'b0;
    step();
    chk(tag, "busy_start", busy, 1);
    chk(tag, "cs_before_decode", cs, 0);
    step();
    chk(tag, "cs", cs, exp_cs);
    chk(tag, "unmapped_pulse", unmapped, (exp_idx < 0) ? 1 : 0);
    if (exp_idx >= 0) chk(tag, "hit_idx", hit_idx, 6'(exp_idx));
    k = 1;
    cs_bad = 0;
    while (dtack_n && k < 60) begin
      step();
      k++;
      if (cs !== exp_cs) cs_bad = 1;
    end
    chk(tag, "dtack_latency", k, exp_lat);
    chk(tag, "cs_stable", cs_bad, 0);
    chk(tag, "unmapped_single", unmapped, 0);
    cpu_as_n = 1'b1;
    step();
    chk(tag, "dtack_release", dtack_n, 1);
    chk(tag, "cs_release", cs, 0);
    chk(tag, "busy_end", busy, 0);
    step();
  endtask

  initial begin
    int k;
    bit early;
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_start = '0;
    cfg_end = '0; cfg_ws = '0; cfg_rwm = '0; cfg_ext = 1'b0;
    cpu_a = '0; cpu_as_n = 1'b1; cpu_rw = 1'b1; ext_ready = 1'b1;
    model_clear();

    vecs[0]  = '{24'h012344, 1'b1,  0,  3};
    vecs[1]  = '{24'h080000, 1'b0, -1, 10};
    vecs[2]  = '{24'h080000, 1'b1,  3,  4};
    vecs[3]  = '{24'h08C010, 1'b1,  2,  5};
    vecs[4]  = '{24'h08E000, 1'b0,  5,  6};
    vecs[5]  = '{24'hAF1234, 1'b1,  7,  3};
    vecs[6]  = '{24'h090800, 1'b1, -1, 10};
    vecs[7]  = '{24'h0A0000, 1'b1, -1, 10};
    vecs[8]  = '{24'h0A8100, 1'b1, -1, 10};
    vecs[9]  = '{24'h0B0100, 1'b1, -1, 10};
    vecs[10] = '{24'h880001, 1'b1,  3,  4};
    vecs[11] = '{24'h07FFFF, 1'b0,  0,  3};
    vecs[12] = '{24'h080002, 1'b1, -1, 10};
    vecs[13] = '{24'h08CFFF, 1'b1,  2,  5};
    vecs[14] = '{24'h08D000, 1'b1,  5,  6};

    step(); step();
    chk("reset", "cs", cs, 0);
    chk("reset", "hit_idx", hit_idx, 0);
    chk("reset", "dtack_n", dtack_n, 1);
    chk("reset", "unmapped", unmapped, 0);
    chk("reset", "busy", busy, 0);
    reset = 1'b0;
    step();

    cfg_write(0,  1, 'h00000, 'h7FFFF, 0, 0, 0);
    cfg_write(3,  1, 'h80000, 'h80001, 1, 1, 0);
    cfg_write(2,  1, 'h8C000, 'h8CFFF, 2, 0, 0);
    cfg_write(5,  1, 'h8C000, 'h8FFFF, 3, 0, 0);
    cfg_write(7,  1, 'hF0000, 'hFFFFF, 0, 0, 0);
    cfg_write(4,  1, 'h90000, 'h90FFF, 0, 3, 0);
    cfg_write(9,  1, 'hA0000, 'h9FFFF, 0, 0, 0);
    cfg_write(10, 0, 'hA8000, 'hA8FFF, 0, 0, 0);
    cfg_write(40, 1, 'hB0000, 'hB0FFF, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      do_access(vecs[i].a, vecs[i].rw, vecs[i].idx, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // External-ready stall: ws=2 but ext_ready held low for 10 cycles.
    cfg_write(6, 1, 'hC0000, 'hC0FFF, 2, 0, 1);
    ext_ready = 1'b0;
    cpu_a = 24'h0C0000; cpu_rw = 1'b1; cpu_as_n = 1'b0;
    step();
    early = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!dtack_n) early = 1;
    end
    chk("ext", "no_early_dtack", early, 0);
    chk("ext", "cs", cs, NREG'(1) << 6);
    ext_ready = 1'b1;
    step();
    chk("ext", "dtack_after_ready_edge", dtack_n, 1);
    step();
    chk("ext", "dtack_next_cycle", dtack_n, 0);
    cpu_as_n = 1'b1;
    step();
    chk("ext", "dtack_release", dtack_n, 1);
    step();

    // Rewrite entry0 mid-access: the in-flight access keeps ws=4.
    cfg_write(0, 1, 'h00000, 'h7FFFF, 4, 0, 0);
    cpu_a = 24'h012344; cpu_rw = 1'b1; cpu_as_n = 1'b0;
    step(); step();
    chk("rewrite", "cs", cs, 1);
    cfg_idx = 6'd0; cfg_en = 1'b1; cfg_start = '0; cfg_end = 20'h7FFFF;
    cfg_ws = '0; cfg_rwm = 2'd0; cfg_ext = 1'b0; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    m_ws[0] = 0;
    k = 2;
    while (dtack_n && k < 60) begin
      step();
      k++;
    end
    chk("rewrite", "old_latency", k, 7);
    cpu_as_n = 1'b1;
    step(); step();
    do_access(24'h012344, 1'b1, 0, 3, "rewrite_after");

    // Abort in WAIT: strobe rises before DTACK.
    cfg_write(0, 1, 'h00000, 'h7FFFF, 6, 0, 0);
    cpu_a = 24'h000100; cpu_rw = 1'b0; cpu_as_n = 1'b0;
    step(); step(); step();
    chk("abort", "cs_in_wait", cs, 1);
    cpu_as_n = 1'b1;
    early = 0;
    step();
    if (!dtack_n) early = 1;
    chk("abort", "busy", busy, 0);
    chk("abort", "cs", cs, 0);
    step();
    if (!dtack_n) early = 1;
    chk("abort", "no_dtack", early, 0);

    // Asynchronous reset while in WAIT.
    cpu_a = 24'h012344; cpu_rw = 1'b1; cpu_as_n = 1'b0;
    step(); step(); step();
    chk("rst_wait", "busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_wait", "cs", cs, 0);
    chk("rst_wait", "hit_idx", hit_idx, 0);
    chk("rst_wait", "dtack_n", dtack_n, 1);
    chk("rst_wait", "busy", busy, 0);
    chk("rst_wait", "unmapped", unmapped, 0);
    cpu_as_n = 1'b1;
    model_clear();
    step();
    reset = 1'b0;
    step();
    do_access(24'h012344, 1'b1, -1, 3 + UNMAP_WS, "table_cleared");

    // Randomized table and accesses against the model.
    for (int i = 0; i < int'(NREG); i++) begin
      int s, e, r;
      s = int'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 4095));
      else begin
        e = s + int'($urandom_range(0, 600));
        if (e > 4095) e = 4095;
      end
      r = int'($urandom_range(0, 9));
      cfg_write(i, $urandom_range(0, 7) != 0, s, e, int'($urandom_range(0, 3)),
                (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3, 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      logic rw;
      int idx;
      a = {4'($urandom_range(0, 15)), 8'h00, 12'($urandom_range(0, 4095))};
      rw = 1'($urandom_range(0, 1));
      idx = model_hit(a, rw);
      do_access(a, rw, idx, (idx >= 0) ? 3 + m_ws[idx] : 3 + int'(UNMAP_WS),
                $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
